// File: rtl/light_conflict_monitor.sv
// Traffic-light supervisor: watches the controller's lamp codes for both
// sides, passes legal samples to the lamps with one cycle of latency, and
// latches the first violation into a flashing-red FAULT state.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_INIT  | lamps red; next sample seeds colours/dwell or faults
// S_MON   | lamps follow inputs delayed one cycle; every sample checked
// S_FAULT | lamps flash red/dark; first fault_code held until clr_fault
module light_conflict_monitor #(
   parameter int YEL_LEN    = 3,
   parameter int GRN_MAX    = 10,
   parameter int FLASH_HALF = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] lightA,
   input  logic [2:0] lightB,
   input  logic       clr_fault,
   output logic [2:0] lampA,
   output logic [2:0] lampB,
   output logic       fault,
   output logic [2:0] fault_code
);

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] DARK = 3'b000;

   // Dwell must represent GRN_MAX+1 and YEL_LEN+1 without wrapping; the
   // counter saturates at all-ones, which is always above both limits.
   localparam int DW_MAX = ((YEL_LEN > GRN_MAX) ? YEL_LEN : GRN_MAX) + 1;
   localparam int DW     = $clog2(DW_MAX + 1);
   localparam int FW     = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

   localparam logic [DW-1:0] DWELL_ONE = DW'(1);
   localparam logic [DW-1:0] DWELL_SAT = {DW{1'b1}};
   localparam logic [DW-1:0] YEL_TC    = DW'(YEL_LEN);
   localparam logic [DW-1:0] GRN_TC    = DW'(GRN_MAX);
   localparam logic [FW-1:0] FLASH_TC  = FW'(FLASH_HALF - 1);

   typedef enum logic [1:0] {
      S_INIT,
      S_MON,
      S_FAULT
   } state_t;

   state_t        state;
   logic [2:0]    col_a, col_b;
   logic [DW-1:0] dwell_a, dwell_b;
   logic [FW-1:0] flash_cnt;
   logic          flash_on;

   logic          conflict;
   logic [2:0]    code_a, code_b, side_code, mon_code, init_code;
   logic [DW-1:0] dwell_a_nxt, dwell_b_nxt;

   function automatic logic is_onehot(input logic [2:0] c);
      return (c == RED) || (c == YEL) || (c == GRN);
   endfunction

   // Per-side rule check; conflict is handled separately since it needs both sides.
   function automatic logic [2:0] side_check(input logic [2:0] prev,
                                             input logic [2:0] cur,
                                             input logic [DW-1:0] cnt);
      logic legal_step;
      legal_step = (cur == prev) ||
                   (prev == GRN && cur == YEL) ||
                   (prev == YEL && cur == RED) ||
                   (prev == RED && cur == GRN);
      if (!is_onehot(cur))
         return 3'd2;
      else if (!legal_step)
         return 3'd3;
      else if (prev == YEL && cur == RED && cnt != YEL_TC)
         return 3'd4;
      else if (prev == GRN && cur == GRN && cnt >= GRN_TC)
         return 3'd5;
      else
         return 3'd0;
   endfunction

   function automatic logic [DW-1:0] dwell_next(input logic [2:0] prev,
                                                input logic [2:0] cur,
                                                input logic [DW-1:0] cnt);
      if (cur != prev)
         return DWELL_ONE;
      else if (cnt == DWELL_SAT)
         return cnt;
      else
         return cnt + DWELL_ONE;
   endfunction

   // Violation decode for the current sample; lowest non-zero code wins.
   always_comb begin
      conflict    = (lightA != RED) && (lightB != RED);
      code_a      = side_check(col_a, lightA, dwell_a);
      code_b      = side_check(col_b, lightB, dwell_b);
      dwell_a_nxt = dwell_next(col_a, lightA, dwell_a);
      dwell_b_nxt = dwell_next(col_b, lightB, dwell_b);
      if (code_a == 3'd0)
         side_code = code_b;
      else if (code_b == 3'd0)
         side_code = code_a;
      else
         side_code = (code_a < code_b) ? code_a : code_b;
      mon_code = conflict ? 3'd1 : side_code;
      if (conflict)
         init_code = 3'd1;
      else if (!is_onehot(lightA) || !is_onehot(lightB))
         init_code = 3'd2;
      else
         init_code = 3'd0;
   end

   // Supervisor FSM with registered lamp and fault outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_INIT;
         lampA      <= RED;
         lampB      <= RED;
         fault      <= 1'b0;
         fault_code <= 3'd0;
         col_a      <= 3'b000;
         col_b      <= 3'b000;
         dwell_a    <= '0;
         dwell_b    <= '0;
         flash_cnt  <= '0;
         flash_on   <= 1'b0;
      end else begin
         case (state)
            S_INIT, S_MON: begin
               if ((state == S_INIT && init_code != 3'd0) ||
                   (state == S_MON && mon_code != 3'd0)) begin
                  state      <= S_FAULT;
                  fault      <= 1'b1;
                  fault_code <= (state == S_INIT) ? init_code : mon_code;
                  lampA      <= RED;
                  lampB      <= RED;
                  flash_cnt  <= FLASH_TC;
                  flash_on   <= 1'b1;
               end else begin
                  state   <= S_MON;
                  lampA   <= lightA;
                  lampB   <= lightB;
                  col_a   <= lightA;
                  col_b   <= lightB;
                  dwell_a <= (state == S_INIT) ? DWELL_ONE : dwell_a_nxt;
                  dwell_b <= (state == S_INIT) ? DWELL_ONE : dwell_b_nxt;
               end
            end
            S_FAULT: begin
               if (clr_fault) begin
                  state      <= S_INIT;
                  fault      <= 1'b0;
                  fault_code <= 3'd0;
                  lampA      <= RED;
                  lampB      <= RED;
               end else if (flash_cnt == '0) begin
                  flash_cnt <= FLASH_TC;
                  flash_on  <= ~flash_on;
                  lampA     <= flash_on ? DARK : RED;
                  lampB     <= flash_on ? DARK : RED;
               end else begin
                  flash_cnt <= flash_cnt - 1'b1;
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Directed bench: stimulus pushes the expected lamp/fault response for the
// next cycle into a queue; a negedge monitor pops and compares.
module tb_light_conflict_monitor;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] D = 3'b000;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] lightA, lightB;
   logic       clr_fault;
   logic [2:0] lampA, lampB;
   logic       fault;
   logic [2:0] fault_code;

   typedef struct {
      int         due;
      logic [2:0] la;
      logic [2:0] lb;
      logic       f;
      logic [2:0] fc;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   light_conflict_monitor #(.YEL_LEN(3), .GRN_MAX(10), .FLASH_HALF(4)) dut (
      .clk(clk), .reset(reset), .lightA(lightA), .lightB(lightB),
      .clr_fault(clr_fault), .lampA(lampA), .lampB(lampB),
      .fault(fault), .fault_code(fault_code)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due in the cycle just completed.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            if (e.due < cyc) begin
               n_bad++;
               $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)", e.name, e.due, cyc);
            end else if ({lampA, lampB, fault, fault_code} !== {e.la, e.lb, e.f, e.fc}) begin
               n_bad++;
               $display("FAIL %s: got lampA=%b lampB=%b fault=%b code=%0d, want lampA=%b lampB=%b fault=%b code=%0d",
                        e.name, lampA, lampB, fault, fault_code, e.la, e.lb, e.f, e.fc);
            end
         end
      end
   end

   task automatic step(input logic [2:0] a, input logic [2:0] b,
                       input logic clr, input logic rst,
                       input logic [2:0] ela, input logic [2:0] elb,
                       input logic ef, input logic [2:0] efc, input string nm);
      exp_t e;
      lightA    = a;
      lightB    = b;
      clr_fault = clr;
      reset     = rst;
      e.due = cyc + 1; e.la = ela; e.lb = elb; e.f = ef; e.fc = efc; e.name = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Eleven further FAULT cycles after entry: 100 x3 more, 000 x4, 100 x4.
   task automatic flash_check(input logic [2:0] code, input string nm);
      for (int i = 1; i < 12; i++)
         step(3'b111, G, 1'b0, 1'b0, ((i / 4) % 2 == 0) ? R : D,
              ((i / 4) % 2 == 0) ? R : D, 1'b1, code, nm);
   endtask

   initial begin
      logic [2:0] a, b;
      reset = 1'b1; lightA = R; lightB = R; clr_fault = 1'b0;
      @(posedge clk); #1;
      step(R, R, 0, 1, R, R, 0, 0, "reset");

      // Nominal: A G8 Y3 R13, B R11 G10 Y3, two full periods.
      for (int p = 0; p < 2; p++)
         for (int t = 0; t < 24; t++) begin
            a = (t < 8) ? G : (t < 11) ? Y : R;
            b = (t < 11) ? R : (t < 21) ? G : Y;
            step(a, b, 0, 0, a, b, 0, 0, "nominal");
         end

      // Conflict, then flash pattern with further violations ignored.
      step(G, R, 0, 0, G, R, 0, 0, "pre_conflict");
      step(G, G, 0, 0, R, R, 1, 1, "conflict");
      flash_check(3'd1, "flash");
      step(G, R, 1, 0, R, R, 0, 0, "clr_to_init");
      step(G, R, 0, 0, G, R, 0, 0, "init_to_mon");
      step(G, R, 1, 0, G, R, 0, 0, "clr_ignored_mon");

      // Yellow too short on A.
      step(Y, R, 0, 0, Y, R, 0, 0, "yel_1");
      step(Y, R, 0, 0, Y, R, 0, 0, "yel_2");
      step(R, R, 0, 0, R, R, 1, 4, "yel_short");
      step(R, R, 1, 0, R, R, 0, 0, "clr2");
      step(G, R, 0, 0, G, R, 0, 0, "init2");
      step(3'b011, G, 0, 0, R, R, 1, 1, "conflict_over_enc");

      // Green timeout on A: 11th green sample faults.
      step(R, R, 1, 0, R, R, 0, 0, "clr3");
      for (int i = 1; i <= 10; i++)
         step(G, R, 0, 0, G, R, 0, 0, "green_ok");
      step(G, R, 0, 0, R, R, 1, 5, "green_timeout");

      // Illegal transition on A (G->R).
      step(R, R, 1, 0, R, R, 0, 0, "clr4");
      step(G, R, 0, 0, G, R, 0, 0, "init4");
      step(R, R, 0, 0, R, R, 1, 3, "illegal_trans");

      // Illegal encoding on B with A red.
      step(R, R, 1, 0, R, R, 0, 0, "clr5");
      step(R, G, 0, 0, R, G, 0, 0, "init5");
      step(R, 3'b110, 0, 0, R, R, 1, 2, "bad_enc_b");

      // Illegal sample while in INIT.
      step(R, R, 1, 0, R, R, 0, 0, "clr6");
      step(G, G, 0, 0, R, R, 1, 1, "init_conflict");

      // Reset overrides clr_fault mid-FAULT.
      step(G, G, 1, 1, R, R, 0, 0, "reset_in_fault");
      step(R, G, 0, 0, R, G, 0, 0, "init7");

      // Yellow too long on B (4 cycles).
      for (int i = 0; i < 4; i++)
         step(R, Y, 0, 0, R, Y, 0, 0, "b_yel");
      step(R, R, 0, 0, R, R, 1, 4, "b_yel_long");

      // Reset mid-MON with a violation on the same edge.
      step(R, R, 1, 1, R, R, 0, 0, "reset_b");
      step(G, R, 0, 0, G, R, 0, 0, "init8");
      step(G, G, 0, 1, R, R, 0, 0, "reset_in_mon");

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/light_conflict_monitor.md
LIGHT_CONFLICT_MONITOR -- requirements
Module: light_conflict_monitor

Interface
REQ-001 The block SHALL have parameter YEL_LEN, default 3, giving the required yellow dwell in cycles.
REQ-002 The block SHALL have parameter GRN_MAX, default 10, giving the maximum legal green dwell in cycles.
REQ-003 The block SHALL have parameter FLASH_HALF, default 4, giving the half-period in cycles of the fault flash.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port lightA, input, 3 bits: the controller's side-A lamp code, one-hot, where 100 = red, 010 = yellow and 001 = green.
REQ-007 Port lightB, input, 3 bits: the controller's side-B lamp code, same encoding as lightA.
REQ-008 Port clr_fault, input, 1 bit: a single-cycle request to leave FAULT.
REQ-009 Port lampA, output, 3 bits: the registered, supervised side-A lamp drive.
REQ-010 Port lampB, output, 3 bits: the registered, supervised side-B lamp drive.
REQ-011 Port fault, output, 1 bit: high exactly while the block is in the FAULT state.
REQ-012 Port fault_code, output, 3 bits: the cause of the first detected violation, held until fault is cleared.

Function
REQ-013 The block SHALL implement the states INIT, MON and FAULT.
REQ-014 In INIT, lampA and lampB SHALL be 100; if the sample is legal, the block SHALL capture per-side colour, set each dwell counter to 1 and go to MON; otherwise it SHALL go to FAULT.
REQ-015 In MON, lampA and lampB SHALL equal lightA and lightB sampled one cycle earlier, giving one cycle of latency.
REQ-016 On each MON sample the block SHALL check for violations; the code values are:
- 1: conflict, i.e. neither side red.
- 2: illegal encoding, i.e. either side not one-hot.
- 3: illegal transition on either side.
- 4: yellow dwell not equal to YEL_LEN.
- 5: green dwell exceeded.
REQ-017 The only legal per-side transitions SHALL be hold, G->Y, Y->R and R->G.
REQ-018 Each side's dwell counter SHALL increment on a repeated colour, reload to 1 on a colour change, and saturate rather than wrap.
REQ-019 Code 4 SHALL fire on the Y->R sample when the yellow count is not YEL_LEN; code 5 SHALL fire on the sample on which the green count would reach GRN_MAX+1.
REQ-020 When several violations occur in one sample, the lowest code SHALL be recorded; side A and side B SHALL be checked with identical rules.
REQ-021 On the cycle after an offending sample, fault SHALL be 1, fault_code SHALL be valid and lamps SHALL be forced; the offending sample SHALL never appear on the lamps.
REQ-022 In FAULT, both lamps SHALL show 100 for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, repeating, starting with 100 on the first FAULT cycle.
REQ-023 In FAULT, further violations SHALL NOT change fault_code.
REQ-024 clr_fault high in FAULT SHALL move the block to INIT on the next cycle, clearing fault and setting fault_code to 0; clr_fault SHALL be ignored in INIT and MON.
REQ-025 The dwell counters and the flash counter SHALL be sized from the parameters so that no overflow occurs.

Reset
REQ-026 While reset is high on a clk edge, the next state SHALL be INIT with lampA = lampB = 100, fault = 0, fault_code = 0 and all counters 0.
REQ-027 Reset SHALL override clr_fault and any violation in the same cycle, and SHALL abort FAULT or MON mid-operation.

Verification
REQ-028 Nominal cycle: A green 8, yellow 3, red 13, with B complementary (red 11, green 10, yellow 3) -> fault stays 0 and lamps equal the inputs delayed 1 cycle.
REQ-029 Conflict: A=001 and B=001 in MON -> next cycle fault = 1, fault_code = 1, lamps = 100, 100.
REQ-030 Yellow too short: A yellow for 2 cycles then red -> fault_code = 4; simultaneously A=011 with B=001 -> fault_code = 1.
REQ-031 Green timeout: A green for 11 cycles -> fault asserts after the 11th sample with fault_code = 5.
REQ-032 Flash and clear: in FAULT, lamps alternate 100 x4 and 000 x4; a clr_fault pulse -> INIT, and a legal sample -> MON.
REQ-033 Reset mid-FAULT with clr_fault also high -> next cycle INIT, fault = 0, fault_code = 0, lamps = 100, 100.
